pp_align_accum: RTL and testbench

//  Parametrised, pipelined successor of the single-lane alignment stage of the SD4 MAC.
//  - Takes LANES signed partial products, each with its own exponent.
//  - Aligns all lanes to the per-beat maximum exponent and sums them.
//  - Accumulates beats under a block exponent until in_last, then emits one result.
//  - Sits between partial_product_generator and normalisation/subnormal_handling.

---
 rtl/sd4_mac_pkg.sv | 34 +++
 rtl/pp_lane_align.sv | 23 ++
 rtl/pp_align_accum.sv | 157 +++++++++++++++
 tb/tb_pp_align_accum.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd4_mac_pkg.sv
// Shared widths and arithmetic helpers for the SD4 MAC alignment/accumulate datapath.
package sd4_mac_pkg;
    localparam int EXP_W      = 5;
    localparam int PP_W       = 5;
    localparam int ALIGN_W    = 16;
    localparam int ACC_W      = 24;
    localparam int LANES_DEF  = 9;
    localparam int LANE_SUM_W = ALIGN_W + $clog2(LANES_DEF);

    typedef struct packed {
        logic                    sat;
        logic signed [ACC_W-1:0] val;
    } sat_res_t;

    function automatic sat_res_t sat_add(input logic signed [ACC_W-1:0] a,
                                         input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        sat_res_t              r;
        s     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        r.sat = (s[ACC_W] != s[ACC_W-1]);
        if (!r.sat)
            r.val = s[ACC_W-1:0];
        else if (s[ACC_W])
            r.val = {1'b1, {(ACC_W-1){1'b0}}};
        else
            r.val = {1'b0, {(ACC_W-1){1'b1}}};
        return r;
    endfunction

    function automatic logic [EXP_W-1:0] max_exp(input logic [EXP_W-1:0] a,
                                                 input logic [EXP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pp_lane_align.sv
// One lane: place the signed pp at the MSBs and shift it down to the beat's max exponent.
// Purely combinational; shifts past the lane width flush to zero.
module pp_lane_align
    import sd4_mac_pkg::*;
(
    input  logic [EXP_W-1:0]          exp_i,
    input  logic [EXP_W-1:0]          exp_max_i,
    input  logic signed [PP_W-1:0]    pp_i,
    input  logic                      en_i,
    output logic signed [ALIGN_W-1:0] aligned_o
);
    logic [EXP_W-1:0]          d;
    logic signed [ALIGN_W-1:0] placed;

    assign d      = exp_max_i - exp_i;
    assign placed = {pp_i, {(ALIGN_W-PP_W){1'b0}}};

    always_comb begin
        aligned_o = '0;
        if (en_i && (int'(d) < ALIGN_W))
            aligned_o = placed >>> d;
    end
endmodule

// File: rtl/pp_align_accum.sv
// Align LANES partial products to a common exponent, sum, and accumulate beats until in_last.
// Latency 3 cycles; a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
module pp_align_accum
    import sd4_mac_pkg::*;
#(
    parameter int LANES = LANES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [LANES-1:0]         in_lane_en,
    input  logic [LANES*EXP_W-1:0]   in_exp,
    input  logic [LANES*PP_W-1:0]    in_pp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic [EXP_W-1:0]         out_exp,
    output logic                     out_sat
);
    localparam int SUM_W = ALIGN_W + $clog2(LANES);

    logic                      en;
    logic [EXP_W-1:0]          eb_d;
    logic                      s1_vld_q, s1_last_q, s1_zero_q;
    logic [LANES-1:0]          s1_en_q;
    logic [LANES*EXP_W-1:0]    s1_exp_q;
    logic [LANES*PP_W-1:0]     s1_pp_q;
    logic [EXP_W-1:0]          s1_eb_q;
    logic signed [ALIGN_W-1:0] aligned [LANES];
    logic signed [SUM_W-1:0]   sum_d, s2_sum_q;
    logic                      s2_vld_q, s2_last_q, s2_zero_q;
    logic [EXP_W-1:0]          s2_eb_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_al, beat_al;
    logic [EXP_W-1:0]          acc_exp_q, acc_exp_d, e_max, da, db;
    logic                      busy_q, sat_q, sat_d;
    sat_res_t                  add_r;
    logic                      out_vld_q, out_sat_q;
    logic signed [ACC_W-1:0]   out_sum_q;
    logic [EXP_W-1:0]          out_exp_q;

    assign en       = !(out_vld_q && !out_ready);
    assign in_ready = en;

    always_comb begin
        eb_d = '0;
        for (int i = 0; i < LANES; i++)
            if (in_lane_en[i])
                eb_d = max_exp(eb_d, in_exp[i*EXP_W +: EXP_W]);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pp_lane_align u_align (
            .exp_i     (s1_exp_q[g*EXP_W +: EXP_W]),
            .exp_max_i (s1_eb_q),
            .pp_i      (s1_pp_q[g*PP_W +: PP_W]),
            .en_i      (s1_en_q[g]),
            .aligned_o (aligned[g])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++)
            sum_d = sum_d + SUM_W'(aligned[i]);
    end

    // Bring accumulator and beat to the larger exponent before the saturating add.
    always_comb begin
        e_max   = max_exp(acc_exp_q, s2_eb_q);
        da      = e_max - acc_exp_q;
        db      = e_max - s2_eb_q;
        acc_al  = '0;
        beat_al = '0;
        if (int'(da) < ACC_W)
            acc_al = acc_q >>> da;
        if (int'(db) < ACC_W)
            beat_al = ACC_W'(s2_sum_q) >>> db;
        add_r     = sat_add(acc_al, beat_al);
        acc_d     = acc_q;
        acc_exp_d = acc_exp_q;
        sat_d     = sat_q;
        if (!s2_zero_q) begin
            if (!busy_q) begin
                acc_d     = ACC_W'(s2_sum_q);
                acc_exp_d = s2_eb_q;
                sat_d     = 1'b0;
            end else begin
                acc_d     = add_r.val;
                acc_exp_d = e_max;
                sat_d     = sat_q | add_r.sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_en_q   <= '0;
            s1_exp_q  <= '0;
            s1_pp_q   <= '0;
            s1_eb_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_eb_q   <= '0;
            s2_sum_q  <= '0;
            acc_q     <= '0;
            acc_exp_q <= '0;
            busy_q    <= 1'b0;
            sat_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_sum_q <= '0;
            out_exp_q <= '0;
            out_sat_q <= 1'b0;
        end else if (en) begin
            s1_vld_q  <= in_valid;
            s1_last_q <= in_last;
            s1_zero_q <= ~|in_lane_en;
            s1_en_q   <= in_lane_en;
            s1_exp_q  <= in_exp;
            s1_pp_q   <= in_pp;
            s1_eb_q   <= eb_d;
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            s2_zero_q <= s1_zero_q;
            s2_eb_q   <= s1_eb_q;
            s2_sum_q  <= sum_d;
            out_vld_q <= 1'b0;
            if (s2_vld_q) begin
                if (s2_last_q) begin
                    out_vld_q <= 1'b1;
                    out_sum_q <= acc_d;
                    out_exp_q <= acc_exp_d;
                    out_sat_q <= sat_d;
                    acc_q     <= '0;
                    acc_exp_q <= '0;
                    sat_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end else begin
                    acc_q     <= acc_d;
                    acc_exp_q <= acc_exp_d;
                    sat_q     <= sat_d;
                    busy_q    <= busy_q | ~s2_zero_q;
                end
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_sum   = out_sum_q;
    assign out_exp   = out_exp_q;
    assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_pp_align_accum.sv
// Scoreboard bench for pp_align_accum: expected results queued at stimulus, popped at output handshake.
module tb_pp_align_accum;
    import sd4_mac_pkg::*;
    localparam int LANES = 9;

    typedef struct packed {
        logic signed [ACC_W-1:0] sum;
        logic [EXP_W-1:0]        exp;
        logic                    sat;
    } res_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid, in_ready, in_last;
    logic [LANES-1:0]        in_lane_en;
    logic [LANES*EXP_W-1:0]  in_exp;
    logic [LANES*PP_W-1:0]   in_pp;
    logic                    out_valid, out_ready, out_sat;
    logic signed [ACC_W-1:0] out_sum;
    logic [EXP_W-1:0]        out_exp;

    res_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               b_exp [LANES];
    int               b_pp  [LANES];
    logic [LANES-1:0] b_en;

    pp_align_accum #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_lane_en (in_lane_en),
        .in_exp     (in_exp),
        .in_pp      (in_pp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_exp    (out_exp),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        b_en = '0;
        for (int i = 0; i < LANES; i++) begin
            b_exp[i] = 0;
            b_pp[i]  = 0;
        end
    endtask

    task automatic set_lane(input int i, input int e, input int p);
        b_en[i]  = 1'b1;
        b_exp[i] = e;
        b_pp[i]  = p;
    endtask

    task automatic push(input longint s, input int e, input logic sat);
        res_t r;
        r.sum = ACC_W'(s);
        r.exp = EXP_W'(e);
        r.sat = sat;
        exp_q.push_back(r);
    endtask

    // Reference for a single-beat accumulation: value pp*2^11 scaled by 2^-(emax-exp), floored.
    function automatic res_t model_single();
        int     eb = 0;
        longint s  = 0;
        res_t   r;
        for (int i = 0; i < LANES; i++)
            if (b_en[i] && b_exp[i] > eb) eb = b_exp[i];
        for (int i = 0; i < LANES; i++) begin
            int d;
            d = eb - b_exp[i];
            if (b_en[i] && d < ALIGN_W)
                s += (longint'(b_pp[i]) * (longint'(1) << (ALIGN_W - PP_W))) >>> d;
        end
        r.sum = ACC_W'(s);
        r.exp = EXP_W'(eb);
        r.sat = 1'b0;
        return r;
    endfunction

    task automatic send_beat(input logic last);
        int   waited = 0;
        logic took;
        in_valid   = 1'b1;
        in_last    = last;
        in_lane_en = b_en;
        for (int i = 0; i < LANES; i++) begin
            in_exp[i*EXP_W +: EXP_W] = EXP_W'(b_exp[i]);
            in_pp[i*PP_W +: PP_W]    = PP_W'(b_pp[i]);
        end
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!took && waited < 200);
        if (!took) check_eq("in_ready_timeout", longint'(took), 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("drain_queue_left", exp_q.size(), 0);
    endtask

    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_result", longint'(out_valid), 0);
                end else begin
                    r = exp_q.pop_front();
                    check_eq("out_sum", longint'(out_sum), longint'($signed(r.sum)));
                    check_eq("out_exp", longint'(out_exp), longint'(r.exp));
                    check_eq("out_sat", longint'(out_sat), longint'(r.sat));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin : main
        res_t m;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_lane_en = '0;
        in_exp     = '0;
        in_pp      = '0;
        out_ready  = 1'b1;
        tick(3);
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_in_ready", longint'(in_ready), 1);
        check_eq("rst_out_sum", longint'(out_sum), 0);
        check_eq("rst_out_exp", longint'(out_exp), 0);
        check_eq("rst_out_sat", longint'(out_sat), 0);
        rst = 1'b0;
        tick(1);

        // Single beat, with a latency probe.
        clear_lanes(); set_lane(0, 3, -11);
        push(-22528, 3, 1'b0);
        send_beat(1'b1);
        tick(1);
        check_eq("latency_early", longint'(out_valid), 0);
        tick(1);
        check_eq("latency_t3", longint'(out_valid), 1);

        clear_lanes(); set_lane(0, 4, 4); set_lane(1, 3, -11);
        push(-3072, 4, 1'b0);
        send_beat(1'b1);

        clear_lanes(); set_lane(0, 20, 1); set_lane(1, 2, -1);
        push(2048, 20, 1'b0);
        send_beat(1'b1);

        // Two beats with an all-lanes-off beat between; disabled lane exponents are ignored.
        clear_lanes(); set_lane(0, 5, 8);
        send_beat(1'b0);
        clear_lanes(); b_exp[3] = 31; b_pp[3] = 7;
        send_beat(1'b0);
        clear_lanes(); set_lane(0, 6, 8);
        push(24576, 6, 1'b0);
        send_beat(1'b1);

        for (int k = 0; k < 6; k++) begin
            clear_lanes();
            for (int i = 0; i < LANES; i++) begin
                b_exp[i] = int'($urandom_range(0, 31));
                b_pp[i]  = int'($urandom_range(0, 31)) - 16;
            end
            b_en = LANES'($urandom_range(1, (1 << LANES) - 1));
            m = model_single();
            push(longint'($signed(m.sum)), int'(m.exp), m.sat);
            send_beat(1'b1);
        end

        // Saturation boundary: 31 full beats overflow, 30 do not.
        clear_lanes();
        for (int i = 0; i < LANES; i++) set_lane(i, 7, 15);
        push(8388607, 7, 1'b1);
        for (int k = 1; k <= 31; k++) send_beat(k == 31);
        push(8294400, 7, 1'b0);
        for (int k = 1; k <= 30; k++) send_beat(k == 30);
        wait_drain();

        // Backpressure: result held, later beats wait, nothing lost.
        out_ready = 1'b0;
        clear_lanes(); set_lane(0, 3, 5);
        push(10240, 3, 1'b0);
        send_beat(1'b1);
        clear_lanes(); set_lane(0, 4, -11); set_lane(1, 4, 3);
        push(-16384, 4, 1'b0);
        send_beat(1'b1);
        clear_lanes(); set_lane(0, 1, 7);
        push(14336, 1, 1'b0);
        send_beat(1'b1);
        clear_lanes(); set_lane(2, 9, -16);
        push(-32768, 9, 1'b0);
        fork
            send_beat(1'b1);
            begin
                tick(6);
                for (int k = 0; k < 4; k++) begin
                    check_eq("bp_in_ready", longint'(in_ready), 0);
                    check_eq("bp_out_valid", longint'(out_valid), 1);
                    check_eq("bp_hold_sum", longint'(out_sum), 10240);
                    check_eq("bp_hold_exp", longint'(out_exp), 3);
                    tick(1);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with a held result and a partial accumulation in flight.
        out_ready = 1'b0;
        clear_lanes(); set_lane(0, 9, 7);
        send_beat(1'b1);
        send_beat(1'b0);
        send_beat(1'b0);
        tick(3);
        check_eq("pre_rst_out_valid", longint'(out_valid), 1);
        rst = 1'b1;
        tick(1);
        rst       = 1'b0;
        out_ready = 1'b1;
        check_eq("post_rst_out_valid", longint'(out_valid), 0);
        check_eq("post_rst_in_ready", longint'(in_ready), 1);
        check_eq("post_rst_out_sum", longint'(out_sum), 0);
        clear_lanes(); set_lane(0, 3, -11);
        push(-22528, 3, 1'b0);
        send_beat(1'b1);
        wait_drain();
        tick(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
